// File: rtl/s2_pkg.sv
// Shared constants and types for the S2 serial peer.
package s2_pkg;
    localparam int unsigned RX_AW = 3;
    localparam int unsigned TX_AW = 5;
    localparam int unsigned DW    = 8;

    localparam int unsigned RX_FRAME_LEN = RX_AW + DW;
    localparam int unsigned TX_FRAME_LEN = TX_AW + DW;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} tx_state_e;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;
endpackage

// File: rtl/s2_serial_peer_if.sv
// Control, status and RB2 buffer bus of the S2 serial peer.
interface s2_serial_peer_if;
    import s2_pkg::*;

    logic                updown;
    logic                S2_done;
    logic                rx_err;
    logic                RB2_RW;
    logic [TX_AW-1:0]    RB2_A;
    logic [DW-1:0]       RB2_D;
    logic [DW-1:0]       RB2_Q;

    modport master (
        output updown, RB2_Q,
        input  S2_done, rx_err, RB2_RW, RB2_A, RB2_D
    );

    modport slave (
        input  updown, RB2_Q,
        output S2_done, rx_err, RB2_RW, RB2_A, RB2_D
    );
endinterface

// File: rtl/s2_rx_deser.sv
// Frame sampler: shifts in sd while sen is low and flags the frame end as valid or erroneous.
module s2_rx_deser
    import s2_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tx,
    input  logic             i_sen,
    input  logic             i_sd,
    output logic             o_valid,
    output logic             o_err,
    output logic [RX_AW-1:0] o_addr,
    output logic [DW-1:0]    o_data
);
    logic [RX_FRAME_LEN-1:0] r_shift;
    logic [3:0]              r_cnt;
    logic                    w_end;

    assign w_end = i_sen && (r_cnt != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= 4'd0;
        end else if (i_tx || w_end) begin
            r_cnt <= 4'd0;
        end else if (!i_sen) begin
            r_shift <= {r_shift[RX_FRAME_LEN-2:0], i_sd};
            // Saturate so overlong frames can never wrap back to a valid count.
            if (r_cnt != 4'hF) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // A complete frame ending as transmit mode starts still gets written; partial ones vanish.
    assign o_valid = w_end && (r_cnt == 4'(RX_FRAME_LEN));
    assign o_err   = w_end && !o_valid && !i_tx;
    assign o_addr  = r_shift[RX_FRAME_LEN-1:DW];
    assign o_data  = r_shift[DW-1:0];
endmodule

// File: rtl/s2_serial_peer.sv
// Far-end S2 peer: receives 11-bit frames into RB2, transmits 13-bit frames from RB2.
module s2_serial_peer
    import s2_pkg::*;
#(
    parameter int unsigned TX_NUM = 18
) (
    input  logic              clk,
    input  logic              rst,
    s2_serial_peer_if.slave   bus,
    inout  wire               sen,
    inout  wire               sd
);
    tx_state_e               r_state, w_state_nxt;
    logic                    r_sen, w_sen_nxt;
    logic                    r_sd, w_sd_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_err;
    logic                    r_rw, w_rw_nxt;
    logic [TX_AW-1:0]        r_a, w_a_nxt;
    logic [DW-1:0]           r_d, w_d_nxt;
    logic [TX_FRAME_LEN-1:0] r_tx, w_tx_nxt;
    logic [3:0]              r_bit, w_bit_nxt;

    logic                    w_rx_valid;
    logic                    w_rx_err;
    logic [RX_AW-1:0]        w_rx_addr;
    logic [DW-1:0]           w_rx_data;
    logic [TX_FRAME_LEN-1:0] w_word;

    s2_rx_deser u_rx (
        .clk     (clk),
        .rst     (rst),
        .i_tx    (bus.updown),
        .i_sen   (sen),
        .i_sd    (sd),
        .o_valid (w_rx_valid),
        .o_err   (w_rx_err),
        .o_addr  (w_rx_addr),
        .o_data  (w_rx_data)
    );

    assign sen = bus.updown ? r_sen : 1'bz;
    assign sd  = bus.updown ? r_sd  : 1'bz;

    assign bus.S2_done = r_done;
    assign bus.rx_err  = r_err;
    assign bus.RB2_RW  = r_rw;
    assign bus.RB2_A   = r_a;
    assign bus.RB2_D   = r_d;

    assign w_word = {r_a, bus.RB2_Q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sen   <= 1'b1;
            r_sd    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rw    <= RD;
            r_a     <= '0;
            r_d     <= '0;
            r_tx    <= '0;
            r_bit   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sen   <= w_sen_nxt;
            r_sd    <= w_sd_nxt;
            r_done  <= w_done_nxt;
            r_err   <= r_err | w_rx_err;
            r_rw    <= w_rw_nxt;
            r_a     <= w_a_nxt;
            r_d     <= w_d_nxt;
            r_tx    <= w_tx_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sen_nxt   = r_sen;
        w_sd_nxt    = r_sd;
        w_done_nxt  = r_done;
        w_rw_nxt    = RD;
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
        w_tx_nxt    = r_tx;
        w_bit_nxt   = r_bit;

        case (r_state)
            IDLE, DONE: begin
                w_sen_nxt = 1'b1;
                w_sd_nxt  = 1'b0;
                if (w_rx_valid) begin
                    // Receive write wins this cycle; transmit starts one cycle later.
                    w_rw_nxt = WR;
                    w_a_nxt  = {{(TX_AW-RX_AW){1'b0}}, w_rx_addr};
                    w_d_nxt  = w_rx_data;
                end else if (r_state == IDLE && bus.updown && !r_done) begin
                    w_state_nxt = FETCH;
                    w_a_nxt     = '0;
                end
            end
            FETCH, SHIFT: begin
                if (!bus.updown) begin
                    w_state_nxt = IDLE;
                    w_a_nxt     = '0;
                    w_sen_nxt   = 1'b1;
                    w_sd_nxt    = 1'b0;
                end else if (r_state == FETCH) begin
                    w_sen_nxt   = 1'b0;
                    w_sd_nxt    = w_word[TX_FRAME_LEN-1];
                    w_tx_nxt    = {w_word[TX_FRAME_LEN-2:0], 1'b0};
                    w_bit_nxt   = 4'(TX_FRAME_LEN - 1);
                    w_state_nxt = SHIFT;
                end else if (r_bit != 4'd0) begin
                    w_sd_nxt  = r_tx[TX_FRAME_LEN-1];
                    w_tx_nxt  = {r_tx[TX_FRAME_LEN-2:0], 1'b0};
                    w_bit_nxt = r_bit - 4'd1;
                end else begin
                    // Last bit has been on the wire for a cycle; FETCH doubles as the gap.
                    w_sen_nxt = 1'b1;
                    w_sd_nxt  = 1'b0;
                    if (r_a == TX_AW'(TX_NUM - 1)) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_a_nxt     = r_a + 1'b1;
                        w_state_nxt = FETCH;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule
